adder_arbiter: RTL and testbench

- Shares one 32-bit combinational adder among N_REQ requesters, e.g. PC increment, branch target and address generation.
- Uses round-robin arbitration with valid/ready handshakes on both sides.
- Registers the sum in a single-entry output slot tagged with the requester id.
- Sits between the processor datapath units and the shared adder, letting the core use one adder instance instead of several.

---
 rtl/adder_arb_pkg.sv | 7 +
 rtl/adder.sv | 10 +
 rtl/adder_arbiter_rr_picker.sv | 31 +++
 rtl/adder_arbiter.sv | 67 ++++++
 tb/tb_adder_arbiter.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared defaults and types for the shared-adder arbiter
package adder_arb_pkg;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 32;
  typedef logic [DEF_WIDTH-1:0] operand_t;
  typedef enum logic {EMPTY, FULL} slot_state_e;
endpackage

// File: rtl/adder.sv
// adder: plain combinational modular adder, carry-out dropped
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C
);
  assign C = A + B;
endmodule

// File: rtl/adder_arbiter_rr_picker.sv
// rr_picker: round-robin priority search starting at ptr, wrapping modulo N_REQ
module rr_picker
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);
  logic [ID_W-1:0] k;
  // first asserted request at or after ptr wins
  always_comb begin
    grant_onehot = '0;
    grant_idx = '0;
    any = 1'b0;
    k = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = ID_W'((int'(ptr) + i) % N_REQ);
      if (enable && !any && req[k]) begin
        grant_onehot[k] = 1'b1;
        grant_idx = k;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one adder with a single-entry tagged result slot
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        rsp_valid,
  output logic [ID_W-1:0]             rsp_id,
  output logic [WIDTH-1:0]            rsp_sum,
  input  logic                        rsp_ready,
  output logic                        busy
);
  slot_state_e state_q, state_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d, rr_ptr_q, rr_ptr_d, grant_idx, nxt_ptr;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d, op_a, op_b, sum;
  logic slot_free, accept;
  assign rsp_valid = state_q == FULL;
  assign rsp_id = rsp_id_q;
  assign rsp_sum = rsp_sum_q;
  assign busy = rsp_valid | (|req_valid);
  assign slot_free = state_q == EMPTY || rsp_ready;
  assign nxt_ptr = grant_idx == ID_W'(N_REQ - 1) ? '0 : grant_idx + 1'b1;
  assign op_a = req_a[grant_idx];
  assign op_b = req_b[grant_idx];
  rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr_q),
    .enable(slot_free && !rst),
    .grant_onehot(req_ready),
    .grant_idx(grant_idx),
    .any(accept)
  );
  adder #(.WIDTH(WIDTH)) u_add (
    .A(op_a),
    .B(op_b),
    .C(sum)
  );
  // an accept overwrites the slot; a bare drain only clears valid
  always_comb begin
    state_d = accept ? FULL : (rsp_valid && rsp_ready) ? EMPTY : state_q;
    rsp_id_d = accept ? grant_idx : rsp_id_q;
    rsp_sum_d = accept ? sum : rsp_sum_q;
    rr_ptr_d = accept ? nxt_ptr : rr_ptr_q;
  end
  // slot and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      rsp_id_q <= '0;
      rsp_sum_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      rsp_id_q <= rsp_id_d;
      rsp_sum_q <= rsp_sum_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and random checks against a behavioural slot model
module tb_adder_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid;
  logic [N-1:0][31:0] req_a, req_b;
  logic [N-1:0] req_ready;
  logic rsp_valid;
  logic [1:0] rsp_id;
  logic [31:0] rsp_sum;
  logic rsp_ready;
  logic busy;
  int n_chk = 0;
  int n_fail = 0;
  bit m_valid = 0;
  int m_id = 0;
  logic [31:0] m_sum = 0;
  int m_ptr = 0;
  logic [N-1:0] obs_rdy;
  int last_grant;
  adder_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_ready(rsp_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    int g;
    bit free;
    logic [31:0] exp_rdy;
    #1;
    free = !m_valid || rsp_ready;
    g = -1;
    if (!rst && free)
      for (int i = 0; i < N; i++) begin
        int j = (m_ptr + i) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    exp_rdy = (g < 0) ? 32'd0 : (32'd1 << g);
    obs_rdy = req_ready;
    last_grant = g;
    chk("req_ready", {28'd0, req_ready}, exp_rdy);
    chk("busy", {31'd0, busy}, {31'd0, m_valid || (|req_valid)});
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_id = 0; m_sum = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1; m_id = g; m_sum = req_a[g] + req_b[g]; m_ptr = (g + 1) % N;
    end else if (m_valid && rsp_ready) m_valid = 0;
    #1;
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    chk("rsp_id", {30'd0, rsp_id}, 32'(m_id));
    chk("rsp_sum", rsp_sum, m_sum);
    @(negedge clk);
  endtask
  initial begin
    logic [31:0] hold_sum;
    logic [1:0] hold_id;
    int ids[5];
    rst = 1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1;
    @(negedge clk);
    cycle();
    rst = 0;
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_sum", rsp_sum, 32'd0);
    // single request
    req_valid = 4'b0001; req_a[0] = 32'h0000000A; req_b[0] = 32'h00000005;
    cycle();
    chk("single_rdy", {28'd0, obs_rdy}, 32'h1);
    chk("single_sum", rsp_sum, 32'h0000000F);
    req_valid = '0;
    cycle();
    // wrap-around on requester 2
    req_valid = 4'b0100; req_a[2] = 32'hFFFFFFFF; req_b[2] = 32'h00000001;
    cycle();
    chk("wrap1_sum", rsp_sum, 32'h0);
    chk("wrap1_id", {30'd0, rsp_id}, 32'd2);
    req_a[2] = 32'h80000000; req_b[2] = 32'h80000000;
    cycle();
    chk("wrap2_sum", rsp_sum, 32'h0);
    req_valid = '0;
    cycle();
    // round robin from a fresh pointer
    rst = 1;
    cycle();
    rst = 0;
    for (int i = 0; i < N; i++) begin
      req_a[i] = 32'(100 * (i + 1)); req_b[i] = 32'(i + 7);
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      ids[i] = int'(rsp_id);
      chk("rr_nobubble", {31'd0, rsp_valid}, 32'd1);
    end
    chk("rr_seq", {ids[0][3:0], ids[1][3:0], ids[2][3:0], ids[3][3:0], ids[4][3:0]}, 32'h01230);
    // backpressure: slot full, consumer stalled
    rsp_ready = 0; req_valid = 4'b0010;
    hold_sum = rsp_sum; hold_id = rsp_id;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_rdy", {28'd0, obs_rdy}, 32'd0);
      chk("bp_sum", rsp_sum, hold_sum);
      chk("bp_id", {30'd0, rsp_id}, {30'd0, hold_id});
    end
    rsp_ready = 1;
    cycle();
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_release_id", {30'd0, rsp_id}, 32'd1);
    // pointer fairness
    req_valid = 4'b1000;
    cycle();
    req_valid = 4'b1001;
    cycle();
    chk("fair_first", 32'(last_grant), 32'd0);
    cycle();
    chk("fair_second", 32'(last_grant), 32'd3);
    // reset mid-operation
    rsp_ready = 0; req_valid = 4'b1111;
    cycle();
    rst = 1;
    cycle();
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_sum", rsp_sum, 32'd0);
    chk("midrst_rdy", {28'd0, obs_rdy}, 32'd0);
    rst = 0; rsp_ready = 1; req_valid = 4'b0110;
    cycle();
    chk("post_rst_grant", {28'd0, obs_rdy}, 32'h2);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[i] = $urandom; req_b[i] = $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
